fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Upstream stage of the instruction decode/execute FSM.
- Reads four bytes from byte-wide main memory (1-cycle synchronous read) and assembles them little-endian into a 32-bit instruction.
- Owns the PC. Drives run/instr to the decoder, waits for ok, applies any branch/jump redirect, then retires the instruction and fetches the next.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- WDT_CYCLES, 64, watchdog limit in cycles (only with FETCH_WATCHDOG_EN).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = sequencing allowed; 0 = stop after current instruction retires.
- MMemory_raddr  out  32  byte address to main memory.
- MMemory_rdata  in  8  byte read; valid the cycle after the address is presented.
- instr  out  32  assembled instruction to decoder; stable while run=1.
- run  out  1  instruction valid / execute request to decoder.
- ok  in  1  decoder done; held until run drops.
- PC_rdata  out  32  current PC; equals fetched address + 4 while run=1.
- PC_decode_wdata  in  32  redirect target from decoder.
- PC_decode_wren  in  1  redirect strobe; may drop in the same cycle ok rises.
- fault  out  1  sticky error: misaligned PC (or watchdog when enabled).
- retired  out  1  one-cycle pulse per retired instruction.

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC.
  - MMemory_raddr=0, instr=0, run=0, fault=0, retired=0.
  - redirect_pend=0, redirect_pc=0.
- IDLE:
  - If enable=1 and fault=0, go to F0.
- F0:
  - If pc[1:0]!=0: set fault=1, go to HALT.
  - Else MMemory_raddr<=pc, go to F1.
- F1:
  - instr[7:0]<=MMemory_rdata, MMemory_raddr<=pc+1.
- F2:
  - instr[15:8]<=rdata, raddr<=pc+2.
- F3:
  - instr[23:16]<=rdata, raddr<=pc+3.
- F4:
  - instr[31:24]<=rdata, pc<=pc+4, run<=1, go to EXEC.
  - Fetch latency: 5 cycles from F0 to run=1.
- EXEC:
  - run held 1; instr and PC_rdata constant.
  - Any cycle with PC_decode_wren=1: redirect_pend<=1, redirect_pc<=PC_decode_wdata. The last strobe wins.
  - When ok=1: run<=0, retired<=1 for one cycle, go to RETIRE.
  - A redirect strobe in the same cycle as ok is still captured.
- RETIRE (exactly one cycle with run=0, so the decoder clears ok):
  - If redirect_pend: pc<=redirect_pc and clear redirect_pend.
  - If enable=1, go to F0; else go to IDLE.
- HALT:
  - run=0 and fault=1 until rst.
  - enable has no effect.
- Address arithmetic is 32-bit modulo. pc=32'hFFFF_FFFC fetches FFFC..FFFF, then wraps to 0.
- enable dropping mid-fetch or mid-EXEC does not abort; the current instruction completes and retires first.
- ok asserted outside EXEC is ignored.
- rst asserted in any state returns immediately to the reset values. No partial instruction is retired.

Optional Feature:
- Macro FETCH_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to EXEC and increments each EXEC cycle without ok.
  - When it reaches WDT_CYCLES: fault<=1, run<=0, go to HALT.
  - This catches the decoder's unknown-opcode trap state.
- Undefined:
  - No counter; EXEC waits for ok indefinitely.
  - WDT_CYCLES is unused.

Decomposition:
- Shared package fetch_pkg:
  - state encoding localparams: IDLE, F0–F4, EXEC, RETIRE, HALT.
  - INSTR_BYTES=4.
  - PC_ALIGN_MASK=2'b11.
- Sub-module: none required. The optional watchdog counter may be split out as fetch_watchdog (inputs clk, rst, clear, tick; output expired).

Test Plan:
- Reset and straight-line fetch:
  - Stimulus: memory[0..3]=8'h21,8'h08,8'h01,8'h20; enable=1; decoder model returns ok 3 cycles after run.
  - Response: instr=32'h2001_0821 and PC_rdata=4 while run=1.
  - Response: MMemory_raddr sequence 0,1,2,3; retired pulse; next fetch at address 4.
- Branch redirect:
  - Stimulus: during EXEC, PC_decode_wren=1 with wdata=32'h40, dropped in the same cycle ok=1.
  - Response: RETIRE lasts one cycle with run=0; next F0 raddr=32'h40.
- Misaligned PC:
  - Stimulus: redirect to 32'h42.
  - Response: fault=1 at next F0; run stays 0; no memory address 0x42 issued; enable toggling has no effect.
- Enable dropped mid-EXEC:
  - Stimulus: enable=0 while run=1.
  - Response: instruction retires normally, state goes to IDLE, no further MMemory_raddr changes.
- Async reset mid-fetch:
  - Stimulus: rst pulse during F2.
  - Response: run=0, instr=0, raddr=0 immediately without a clock edge; after release, fetch restarts from RESET_PC.
- Watchdog (FETCH_WATCHDOG_EN, WDT_CYCLES=8):
  - Stimulus: decoder never asserts ok.
  - Response: fault=1 and run=0 exactly 8 EXEC cycles after run rose.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch sequencer.
//   - fetch_state_e : sequencer state encoding (IDLE, F0..F4, EXEC, RETIRE, HALT)
//   - INSTR_BYTES   : bytes per instruction word
//   - PC_ALIGN_MASK : PC bits that must be zero for a legal fetch
//   - pc_misaligned : alignment test on a PC value
//   - byte_addr     : modulo-2^32 byte address of byte idx within a word at base
package fetch_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    F0     = 4'd1,
    F1     = 4'd2,
    F2     = 4'd3,
    F3     = 4'd4,
    F4     = 4'd5,
    EXEC   = 4'd6,
    RETIRE = 4'd7,
    HALT   = 4'd8
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] & PC_ALIGN_MASK) != 2'b00;
  endfunction

  // Wraps naturally at 2^32, so a word at FFFF_FFFC reads FFFC..FFFF.
  function automatic logic [31:0] byte_addr(input logic [31:0] base, input int unsigned idx);
    return base + 32'(idx);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: EXEC-phase timeout counter for the fetch sequencer.
// Only present when FETCH_WATCHDOG_EN is defined; otherwise this file is empty.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   clear   in  restart the count (asserted the cycle before EXEC is entered)
//   tick    in  one EXEC cycle elapsed without ok
//   expired out the current tick is the LIMIT-th consecutive one
`ifdef FETCH_WATCHDOG_EN
module fetch_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  logic [31:0] count_q, count_d;

  // Flagged on the tick that would make the count reach LIMIT, so the
  // sequencer halts on exactly the LIMIT-th EXEC edge after run rose.
  assign expired = tick && (count_q == 32'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 32-bit instructions byte-by-byte from main memory,
// hands them to the decoder and retires them, owning the PC throughout.
// Optional feature: define FETCH_WATCHDOG_EN to halt with fault when the
// decoder does not answer within WDT_CYCLES EXEC cycles.
// Ports:
//   clk              in   system clock
//   rst              in   asynchronous active-high reset
//   enable           in   allow sequencing; dropping it stops after the current retire
//   MMemory_raddr    out  byte address to main memory (registered)
//   MMemory_rdata    in   byte for the address issued on the previous edge
//   instr            out  assembled little-endian instruction, stable while run=1
//   run              out  instruction valid / execute request
//   ok               in   decoder done, held until run drops
//   PC_rdata         out  current PC (fetched address + 4 while run=1)
//   PC_decode_wdata  in   redirect target
//   PC_decode_wren   in   redirect strobe (last one in EXEC wins)
//   fault            out  sticky: misaligned PC or watchdog expiry
//   retired          out  one-cycle pulse per retired instruction
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WDT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] MMemory_raddr,
  input  logic [7:0]  MMemory_rdata,
  output logic [31:0] instr,
  output logic        run,
  input  logic        ok,
  output logic [31:0] PC_rdata,
  input  logic [31:0] PC_decode_wdata,
  input  logic        PC_decode_wren,
  output logic        fault,
  output logic        retired
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  raddr_q, raddr_d;
  logic [31:0]  instr_q, instr_d;
  logic         run_q, run_d;
  logic         fault_q, fault_d;
  logic         retired_q, retired_d;
  logic         redirect_pend_q, redirect_pend_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic         wdt_expired;

`ifdef FETCH_WATCHDOG_EN
  logic wdt_clear;
  logic wdt_tick;

  // F4 is always the cycle right before EXEC entry.
  assign wdt_clear = (state_q == F4);
  assign wdt_tick  = (state_q == EXEC) && !ok;

  fetch_watchdog #(
    .LIMIT (WDT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wdt_clear),
    .tick    (wdt_tick),
    .expired (wdt_expired)
  );
`else
  logic unused_wdt_cycles;
  assign unused_wdt_cycles = ^WDT_CYCLES;
  assign wdt_expired       = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    raddr_d         = raddr_q;
    instr_d         = instr_q;
    run_d           = run_q;
    fault_d         = fault_q;
    retired_d       = 1'b0;
    redirect_pend_d = redirect_pend_q;
    redirect_pc_d   = redirect_pc_q;

    unique case (state_q)
      IDLE: begin
        if (enable && !fault_q) begin
          state_d = F0;
        end
      end

      F0: begin
        if (pc_misaligned(pc_q)) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          raddr_d = pc_q;
          state_d = F1;
        end
      end

      // Each Fn captures the byte for the address issued one edge earlier
      // and issues the next address.
      F1: begin
        instr_d[7:0] = MMemory_rdata;
        raddr_d      = byte_addr(pc_q, 1);
        state_d      = F2;
      end

      F2: begin
        instr_d[15:8] = MMemory_rdata;
        raddr_d       = byte_addr(pc_q, 2);
        state_d       = F3;
      end

      F3: begin
        instr_d[23:16] = MMemory_rdata;
        raddr_d        = byte_addr(pc_q, 3);
        state_d        = F4;
      end

      F4: begin
        instr_d[31:24] = MMemory_rdata;
        pc_d           = byte_addr(pc_q, INSTR_BYTES);
        run_d          = 1'b1;
        state_d        = EXEC;
      end

      EXEC: begin
        // Captured even in the ok cycle; the decoder may drop the strobe as ok rises.
        if (PC_decode_wren) begin
          redirect_pend_d = 1'b1;
          redirect_pc_d   = PC_decode_wdata;
        end
        if (ok) begin
          run_d     = 1'b0;
          retired_d = 1'b1;
          state_d   = RETIRE;
        end else if (wdt_expired) begin
          fault_d = 1'b1;
          run_d   = 1'b0;
          state_d = HALT;
        end
      end

      // Single cycle with run low so the decoder can release ok.
      RETIRE: begin
        if (redirect_pend_q) begin
          pc_d            = redirect_pc_q;
          redirect_pend_d = 1'b0;
        end
        state_d = enable ? F0 : IDLE;
      end

      HALT: begin
        run_d   = 1'b0;
        fault_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      raddr_q         <= '0;
      instr_q         <= '0;
      run_q           <= 1'b0;
      fault_q         <= 1'b0;
      retired_q       <= 1'b0;
      redirect_pend_q <= 1'b0;
      redirect_pc_q   <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      raddr_q         <= raddr_d;
      instr_q         <= instr_d;
      run_q           <= run_d;
      fault_q         <= fault_d;
      retired_q       <= retired_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  assign MMemory_raddr = raddr_q;
  assign instr         = instr_q;
  assign run           = run_q;
  assign PC_rdata      = pc_q;
  assign fault         = fault_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned WDT      = 8;

  typedef logic [3:0][31:0] addr4_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] MMemory_raddr;
  logic [7:0]  MMemory_rdata;
  logic [31:0] instr;
  logic        run;
  logic        ok;
  logic [31:0] PC_rdata;
  logic [31:0] PC_decode_wdata;
  logic        PC_decode_wren;
  logic        fault;
  logic        retired;

  logic [7:0] mem [1024];
  int total = 0;
  int bad = 0;
  int n_retired = 0;

  fetch_sequencer #(
    .RESET_PC   (RESET_PC),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .MMemory_raddr   (MMemory_raddr),
    .MMemory_rdata   (MMemory_rdata),
    .instr           (instr),
    .run             (run),
    .ok              (ok),
    .PC_rdata        (PC_rdata),
    .PC_decode_wdata (PC_decode_wdata),
    .PC_decode_wren  (PC_decode_wren),
    .fault           (fault),
    .retired         (retired)
  );

  always #5 clk = ~clk;

  // The DUT registers the address, so the byte it needs arrives one edge later.
  assign MMemory_rdata = mem[MMemory_raddr[9:0]];

  always @(negedge clk) if (retired === 1'b1) n_retired++;

  // Reference: an instruction at p is the little-endian word of bytes p..p+3.
  function automatic logic [31:0] model_word(input logic [31:0] p);
    logic [31:0] a;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      a = p + 32'(k);
      w[8*k +: 8] = mem[a[9:0]];
    end
    return w;
  endfunction

  function automatic addr4_t model_addrs(input logic [31:0] p);
    addr4_t r;
    for (int k = 0; k < 4; k++) r[k] = p + 32'(k);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    ok = 1'b0;
    PC_decode_wren = 1'b0;
    PC_decode_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one fetch/execute/retire round as the decoder would and reports
  // what was observed. mode: 0 no redirect, 1 strobe held until ok,
  // 2 strobe only with ok, 3 wrong target first then the real one.
  // drop_en: 0 keep, 1 drop enable in EXEC, 2 drop enable mid-fetch.
  task automatic fetch_one(input int delay, input int mode, input logic [31:0] tgt,
                           input int drop_en, output int lat, output addr4_t addrs,
                           output logic [31:0] got_instr, output logic [31:0] got_pc,
                           output bit stable, output bit ret_run, output bit ret_retired);
    int cyc;
    cyc = 0;
    lat = 99;
    addrs = '0;
    got_instr = '0;
    got_pc = '0;
    stable = 1'b1;
    ret_run = 1'b1;
    ret_retired = 1'b0;
    while (cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc >= 2 && cyc <= 5) addrs[cyc-2] = MMemory_raddr;
      if (drop_en == 2 && cyc == 3) enable = 1'b0;
      if (run === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    if (lat == 99) return;
    got_instr = instr;
    got_pc = PC_rdata;
    if (drop_en == 1) enable = 1'b0;
    if (mode == 1 || mode == 3) begin
      PC_decode_wren = 1'b1;
      PC_decode_wdata = (mode == 3) ? ~tgt : tgt;
    end
    for (int d = 0; d < delay; d++) begin
      @(posedge clk);
      @(negedge clk);
      if (instr !== got_instr || PC_rdata !== got_pc || run !== 1'b1) stable = 1'b0;
      if (mode == 3 && d == 0) PC_decode_wdata = tgt;
    end
    ok = 1'b1;
    if (mode == 2) begin
      PC_decode_wren = 1'b1;
      PC_decode_wdata = tgt;
    end else begin
      PC_decode_wren = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    ret_run = run;
    ret_retired = retired;
    ok = 1'b0;
    PC_decode_wren = 1'b0;
    PC_decode_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    ok = 1'b0;
    PC_decode_wren = 1'b0;
    PC_decode_wdata = '0;
    repeat (3) @(negedge clk);
    total++; if (MMemory_raddr !== 32'h0) begin bad++; $display("FAIL reset_raddr: got %h want 0", MMemory_raddr); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    total++; if ({run, fault, retired} !== 3'b000) begin bad++; $display("FAIL reset_flags: run/fault/retired got %b want 000", {run, fault, retired}); end
    total++; if (PC_rdata !== RESET_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", PC_rdata, RESET_PC); end
    rst = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_straight_line();
    int lat;
    addr4_t ad;
    logic [31:0] gi, gp;
    bit st, rr, rt;
    do_reset();
    enable = 1'b1;
    fetch_one(3, 0, 32'h0, 0, lat, ad, gi, gp, st, rr, rt);
    total++; if (lat !== 6) begin bad++; $display("FAIL straight_latency: got %0d want 6", lat); end
    total++; if (ad !== model_addrs(32'h0)) begin bad++; $display("FAIL straight_addrs: got %h want %h", ad, model_addrs(32'h0)); end
    total++; if (gi !== 32'h2001_0821) begin bad++; $display("FAIL straight_instr: got %h want 20010821", gi); end
    total++; if (gp !== 32'h4) begin bad++; $display("FAIL straight_pc: got %h want 4", gp); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL straight_stable: got %0d want 1", st); end
    total++; if ({rr, rt} !== 2'b01) begin bad++; $display("FAIL straight_retire: run/retired got %b want 01", {rr, rt}); end
    fetch_one(1, 0, 32'h0, 0, lat, ad, gi, gp, st, rr, rt);
    total++; if (ad !== model_addrs(32'h4)) begin bad++; $display("FAIL straight_next_addrs: got %h want %h", ad, model_addrs(32'h4)); end
    total++; if (gi !== model_word(32'h4)) begin bad++; $display("FAIL straight_next_instr: got %h want %h", gi, model_word(32'h4)); end
    enable = 1'b0;
  endtask

  task automatic test_branch();
    int lat;
    addr4_t ad;
    logic [31:0] gi, gp;
    bit st, rr, rt;
    do_reset();
    enable = 1'b1;
    fetch_one(3, 1, 32'h40, 0, lat, ad, gi, gp, st, rr, rt);
    total++; if (rr !== 1'b0) begin bad++; $display("FAIL branch_retire_run: got %0d want 0", rr); end
    fetch_one(2, 0, 32'h0, 0, lat, ad, gi, gp, st, rr, rt);
    total++; if (lat !== 6) begin bad++; $display("FAIL branch_latency: got %0d want 6", lat); end
    total++; if (ad !== model_addrs(32'h40)) begin bad++; $display("FAIL branch_addrs: got %h want %h", ad, model_addrs(32'h40)); end
    total++; if (gi !== model_word(32'h40)) begin bad++; $display("FAIL branch_instr: got %h want %h", gi, model_word(32'h40)); end
    total++; if (gp !== 32'h44) begin bad++; $display("FAIL branch_pc: got %h want 44", gp); end
    enable = 1'b0;
  endtask

  task automatic test_random();
    int lat, delay, mode, r0;
    addr4_t ad;
    logic [31:0] gi, gp, tgt, m_pc;
    bit st, rr, rt;
    do_reset();
    enable = 1'b1;
    m_pc = RESET_PC;
    r0 = n_retired;
    for (int i = 0; i < 30; i++) begin
      delay = int'($urandom_range(1, 5));
      mode = int'($urandom_range(0, 3));
      if (mode == 3 && delay < 2) delay = 2;
      tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      fetch_one(delay, mode, tgt, 0, lat, ad, gi, gp, st, rr, rt);
      total++; if (lat !== 6) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want 6", i, lat); end
      total++; if (ad !== model_addrs(m_pc)) begin bad++; $display("FAIL rand_addrs[%0d]: got %h want %h", i, ad, model_addrs(m_pc)); end
      total++; if (gi !== model_word(m_pc)) begin bad++; $display("FAIL rand_instr[%0d]: got %h want %h", i, gi, model_word(m_pc)); end
      total++; if (gp !== m_pc + 32'd4) begin bad++; $display("FAIL rand_pc[%0d]: got %h want %h", i, gp, m_pc + 32'd4); end
      total++; if ({st, rr, rt} !== 3'b101) begin bad++; $display("FAIL rand_exec[%0d]: stable/run/retired got %b want 101", i, {st, rr, rt}); end
      m_pc = (mode == 0) ? m_pc + 32'd4 : tgt;
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (n_retired - r0 !== 30) begin bad++; $display("FAIL rand_retired_count: got %0d want 30", n_retired - r0); end
  endtask

  task automatic test_wrap();
    int lat;
    addr4_t ad;
    logic [31:0] gi, gp;
    bit st, rr, rt;
    do_reset();
    enable = 1'b1;
    fetch_one(1, 1, 32'hFFFF_FFFC, 0, lat, ad, gi, gp, st, rr, rt);
    fetch_one(1, 0, 32'h0, 0, lat, ad, gi, gp, st, rr, rt);
    total++; if (ad !== model_addrs(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_addrs: got %h want %h", ad, model_addrs(32'hFFFF_FFFC)); end
    total++; if (gi !== model_word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_instr: got %h want %h", gi, model_word(32'hFFFF_FFFC)); end
    total++; if (gp !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 0", gp); end
    fetch_one(1, 0, 32'h0, 0, lat, ad, gi, gp, st, rr, rt);
    total++; if (ad !== model_addrs(32'h0)) begin bad++; $display("FAIL wrap_next_addrs: got %h want %h", ad, model_addrs(32'h0)); end
    enable = 1'b0;
  endtask

  task automatic test_misaligned();
    int lat, first;
    addr4_t ad;
    logic [31:0] gi, gp, ra;
    bit st, rr, rt, changed, saw42, run_seen;
    do_reset();
    enable = 1'b1;
    fetch_one(2, 1, 32'h42, 0, lat, ad, gi, gp, st, rr, rt);
    ra = MMemory_raddr;
    first = 0;
    changed = 1'b0;
    saw42 = 1'b0;
    run_seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (MMemory_raddr !== ra) changed = 1'b1;
      if (MMemory_raddr === 32'h42) saw42 = 1'b1;
      if (run === 1'b1) run_seen = 1'b1;
      if (fault === 1'b1 && first == 0) first = k;
      enable = ~enable;
    end
    total++; if (first !== 2) begin bad++; $display("FAIL misalign_fault_cycle: got %0d want 2", first); end
    total++; if ({changed, saw42} !== 2'b00) begin bad++; $display("FAIL misalign_addr: changed/saw42 got %b want 00", {changed, saw42}); end
    total++; if (run_seen !== 1'b0) begin bad++; $display("FAIL misalign_run: got %0d want 0", run_seen); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL misalign_sticky: got %0d want 1", fault); end
    do_reset();
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL misalign_reset_clear: got %0d want 0", fault); end
  endtask

  task automatic test_enable_drop();
    int lat, r0;
    addr4_t ad;
    logic [31:0] gi, gp, ra;
    bit st, rr, rt, changed, run_seen;
    do_reset();
    enable = 1'b1;
    r0 = n_retired;
    fetch_one(2, 0, 32'h0, 1, lat, ad, gi, gp, st, rr, rt);
    total++; if (rt !== 1'b1) begin bad++; $display("FAIL endrop_retired: got %0d want 1", rt); end
    ra = MMemory_raddr;
    changed = 1'b0;
    run_seen = 1'b0;
    ok = 1'b1;  // ok outside EXEC must be ignored
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (MMemory_raddr !== ra) changed = 1'b1;
      if (run === 1'b1) run_seen = 1'b1;
    end
    ok = 1'b0;
    total++; if ({changed, run_seen} !== 2'b00) begin bad++; $display("FAIL endrop_idle: changed/run got %b want 00", {changed, run_seen}); end
    total++; if (n_retired - r0 !== 1) begin bad++; $display("FAIL endrop_count: got %0d want 1", n_retired - r0); end
    enable = 1'b1;
    fetch_one(1, 0, 32'h0, 2, lat, ad, gi, gp, st, rr, rt);
    total++; if (ad !== model_addrs(32'h4)) begin bad++; $display("FAIL endrop_fetch_addrs: got %h want %h", ad, model_addrs(32'h4)); end
    total++; if (gi !== model_word(32'h4)) begin bad++; $display("FAIL endrop_fetch_instr: got %h want %h", gi, model_word(32'h4)); end
    changed = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (MMemory_raddr !== 32'h7 || run !== 1'b0) changed = 1'b1;
    end
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL endrop_midfetch_idle: got %0d want 0", changed); end
  endtask

  task automatic test_async_reset();
    int lat, r0;
    addr4_t ad;
    logic [31:0] gi, gp;
    bit st, rr, rt;
    do_reset();
    enable = 1'b1;
    fetch_one(1, 0, 32'h0, 0, lat, ad, gi, gp, st, rr, rt);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    r0 = n_retired;
    total++; if (MMemory_raddr !== 32'h5) begin bad++; $display("FAIL arst_pre_raddr: got %h want 5", MMemory_raddr); end
    #2 rst = 1'b1;
    #1;
    total++; if ({run, retired, fault} !== 3'b000) begin bad++; $display("FAIL arst_flags: run/retired/fault got %b want 000", {run, retired, fault}); end
    total++; if (instr !== 32'h0 || MMemory_raddr !== 32'h0) begin bad++; $display("FAIL arst_regs: instr %h raddr %h want 0 0", instr, MMemory_raddr); end
    total++; if (PC_rdata !== RESET_PC) begin bad++; $display("FAIL arst_pc: got %h want %h", PC_rdata, RESET_PC); end
    @(negedge clk);
    rst = 1'b0;
    fetch_one(1, 0, 32'h0, 0, lat, ad, gi, gp, st, rr, rt);
    total++; if (ad !== model_addrs(RESET_PC)) begin bad++; $display("FAIL arst_restart_addrs: got %h want %h", ad, model_addrs(RESET_PC)); end
    total++; if (gi !== 32'h2001_0821) begin bad++; $display("FAIL arst_restart_instr: got %h want 20010821", gi); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (n_retired - r0 !== 1) begin bad++; $display("FAIL arst_retired_count: got %0d want 1", n_retired - r0); end
  endtask

`ifdef FETCH_WATCHDOG_EN
  task automatic test_watchdog();
    int cyc, first;
    bit run_at_fault, early;
    do_reset();
    enable = 1'b1;
    cyc = 0;
    while (cyc < 20 && run !== 1'b1) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    total++; if (run !== 1'b1) begin bad++; $display("FAIL wdt_run_rise: got %b want 1", run); end
    first = 0;
    run_at_fault = 1'b1;
    early = 1'b0;
    for (int k = 1; k <= 3 * WDT; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (fault === 1'b1 && first == 0) begin
        first = k;
        run_at_fault = run;
      end
    end
    if (first != 0 && first < int'(WDT)) early = 1'b1;
    total++; if (first !== int'(WDT)) begin bad++; $display("FAIL wdt_cycle: got %0d want %0d", first, WDT); end
    total++; if ({run_at_fault, early} !== 2'b00) begin bad++; $display("FAIL wdt_run: run/early got %b want 00", {run_at_fault, early}); end
    enable = 1'b0;
  endtask
`else
  task automatic test_no_watchdog();
    int cyc;
    bit dropped;
    do_reset();
    enable = 1'b1;
    cyc = 0;
    while (cyc < 20 && run !== 1'b1) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    dropped = 1'b0;
    for (int k = 0; k < 5 * WDT; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (run !== 1'b1 || fault !== 1'b0) dropped = 1'b1;
    end
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL nowdt_wait: got %0d want 0", dropped); end
    ok = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if ({run, retired} !== 2'b01) begin bad++; $display("FAIL nowdt_retire: run/retired got %b want 01", {run, retired}); end
    ok = 1'b0;
    enable = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h21;
    mem[1] = 8'h08;
    mem[2] = 8'h01;
    mem[3] = 8'h20;
    test_reset();
    test_straight_line();
    test_branch();
    test_random();
    test_wrap();
    test_misaligned();
    test_enable_drop();
    test_async_reset();
`ifdef FETCH_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
